// File: rtl/ofs_fim_eth_if_pkg.sv
// Shared Ethernet RX definitions: error sideband width, frame classes,
// monitor FSM states and small helpers used by the RX packet monitor.
package ofs_fim_eth_if_pkg;

    localparam int ETH_RX_ERROR_WIDTH = 2;

    typedef enum logic [1:0] {
        CLS_GOOD,
        CLS_ERR,
        CLS_RUNT,
        CLS_OVERSIZE
    } eth_frame_class_e;

    typedef enum logic {
        ST_IDLE,
        ST_IN_PKT
    } eth_rx_mon_state_e;

    // Number of valid bytes in a beat (tkeep bits set).
    function automatic logic [3:0] keep_popcount(input logic [7:0] keep);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, keep[i]};
        end
        return n;
    endfunction

    // Error wins over runt, runt over oversize, oversize over good.
    function automatic eth_frame_class_e classify_frame(
        input logic        err,
        input logic [15:0] len,
        input logic [15:0] min_len,
        input logic [15:0] max_len
    );
        eth_frame_class_e cls;
        if (err) begin
            cls = CLS_ERR;
        end else if (len < min_len) begin
            cls = CLS_RUNT;
        end else if (len > max_len) begin
            cls = CLS_OVERSIZE;
        end else begin
            cls = CLS_GOOD;
        end
        return cls;
    endfunction

endpackage

// File: rtl/eth_sat_counter.sv
// Saturating statistics counter: adds inc_amount when inc is set, sticks at
// all-ones instead of wrapping, and a synchronous clear beats any increment.
module eth_sat_counter #(
    parameter int WIDTH     = 32,
    parameter int INC_WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 inc,
    input  logic [INC_WIDTH-1:0] inc_amount,
    output logic [WIDTH-1:0]     count
);

    localparam int SUM_WIDTH = ((WIDTH > INC_WIDTH) ? WIDTH : INC_WIDTH) + 1;

    logic [WIDTH-1:0]     r_count;
    logic [SUM_WIDTH-1:0] w_sum;
    logic [SUM_WIDTH-1:0] w_max;

    assign w_sum = SUM_WIDTH'(r_count) + SUM_WIDTH'(inc_amount);
    assign w_max = SUM_WIDTH'({WIDTH{1'b1}});
    assign count = r_count;

    // Count register: clear has priority, otherwise add and clamp at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= (w_sum > w_max) ? '1 : w_sum[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/eth_rx_axis_pkt_mon.sv
// RX AXI-Stream packet monitor: a one-stage register slice between the RX CDC
// FIFO and the traffic checker, classifying every frame it carries and keeping
// saturating good/error/runt/oversize/byte statistics.
module eth_rx_axis_pkt_mon
    import ofs_fim_eth_if_pkg::*;
#(
    parameter int CNT_WIDTH     = 32,
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_tvalid,
    input  logic                          s_tlast,
    input  logic [63:0]                   s_tdata,
    input  logic [7:0]                    s_tkeep,
    input  logic [ETH_RX_ERROR_WIDTH-1:0] s_tuser,
    output logic                          s_tready,
    output logic                          m_tvalid,
    output logic                          m_tlast,
    output logic [63:0]                   m_tdata,
    output logic [7:0]                    m_tkeep,
    output logic [ETH_RX_ERROR_WIDTH-1:0] m_tuser,
    input  logic                          m_tready,
    input  logic                          clr_stats,
    output logic [CNT_WIDTH-1:0]          good_cnt,
    output logic [CNT_WIDTH-1:0]          err_cnt,
    output logic [CNT_WIDTH-1:0]          runt_cnt,
    output logic [CNT_WIDTH-1:0]          oversize_cnt,
    output logic [CNT_WIDTH+7:0]          byte_cnt,
    output logic [15:0]                   last_len,
    output logic                          last_len_vld
);

    logic                          r_m_tvalid;
    logic                          r_m_tlast;
    logic [63:0]                   r_m_tdata;
    logic [7:0]                    r_m_tkeep;
    logic [ETH_RX_ERROR_WIDTH-1:0] r_m_tuser;

    eth_rx_mon_state_e r_state;
    eth_rx_mon_state_e w_state_next;
    logic [15:0]       r_len_acc;
    logic              r_err;
    logic [15:0]       r_last_len;
    logic              r_last_len_vld;

    logic              w_s_hs;
    logic              w_frame_end;
    logic [15:0]       w_len_base;
    logic              w_err_base;
    logic [16:0]       w_len_sum;
    logic [15:0]       w_frame_len;
    logic              w_frame_err;
    eth_frame_class_e  w_frame_cls;
    logic              w_inc_good;
    logic              w_inc_err;
    logic              w_inc_runt;
    logic              w_inc_over;

    assign s_tready    = ~r_m_tvalid | m_tready;
    assign w_s_hs      = s_tvalid & s_tready;
    assign w_frame_end = w_s_hs & s_tlast;

    assign m_tvalid     = r_m_tvalid;
    assign m_tlast      = r_m_tlast;
    assign m_tdata      = r_m_tdata;
    assign m_tkeep      = r_m_tkeep;
    assign m_tuser      = r_m_tuser;
    assign last_len     = r_last_len;
    assign last_len_vld = r_last_len_vld;

    // Output valid follows the sink whenever the slice is free to load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_tvalid <= 1'b0;
        end else if (s_tready) begin
            r_m_tvalid <= s_tvalid;
        end
    end

    // Payload registers load only on an accepted beat and need no reset.
    always_ff @(posedge clk) begin
        if (w_s_hs) begin
            r_m_tdata <= s_tdata;
            r_m_tkeep <= s_tkeep;
            r_m_tuser <= s_tuser;
            r_m_tlast <= s_tlast;
        end
    end

    // Frame tracking state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus running length/error, restarting whenever we are idle.
    always_comb begin
        w_state_next = r_state;
        w_len_base   = 16'h0000;
        w_err_base   = 1'b0;
        if (r_state == ST_IN_PKT) begin
            w_len_base = r_len_acc;
            w_err_base = r_err;
        end
        w_len_sum   = {1'b0, w_len_base} + {13'h0000, keep_popcount(s_tkeep)};
        w_frame_len = w_len_sum[16] ? 16'hFFFF : w_len_sum[15:0];
        w_frame_err = w_err_base | (|s_tuser);
        w_frame_cls = classify_frame(w_frame_err, w_frame_len,
                                     16'(MIN_FRAME_LEN), 16'(MAX_FRAME_LEN));
        if (w_s_hs) begin
            w_state_next = s_tlast ? ST_IDLE : ST_IN_PKT;
        end
    end

    // Length accumulator and sticky error, emptied again at each frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len_acc <= 16'h0000;
            r_err     <= 1'b0;
        end else if (w_s_hs) begin
            r_len_acc <= s_tlast ? 16'h0000 : w_frame_len;
            r_err     <= s_tlast ? 1'b0 : w_frame_err;
        end
    end

    // Most recent frame length with a one-cycle strobe; not affected by clr_stats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_len     <= 16'h0000;
            r_last_len_vld <= 1'b0;
        end else begin
            r_last_len_vld <= w_frame_end;
            if (w_frame_end) begin
                r_last_len <= w_frame_len;
            end
        end
    end

    assign w_inc_good = w_frame_end & (w_frame_cls == CLS_GOOD);
    assign w_inc_err  = w_frame_end & (w_frame_cls == CLS_ERR);
    assign w_inc_runt = w_frame_end & (w_frame_cls == CLS_RUNT);
    assign w_inc_over = w_frame_end & (w_frame_cls == CLS_OVERSIZE);

    eth_sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_good_cnt (
        .clk(clk), .rst(rst), .clr(clr_stats), .inc(w_inc_good),
        .inc_amount(1'b1), .count(good_cnt)
    );

    eth_sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_err_cnt (
        .clk(clk), .rst(rst), .clr(clr_stats), .inc(w_inc_err),
        .inc_amount(1'b1), .count(err_cnt)
    );

    eth_sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_runt_cnt (
        .clk(clk), .rst(rst), .clr(clr_stats), .inc(w_inc_runt),
        .inc_amount(1'b1), .count(runt_cnt)
    );

    eth_sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_oversize_cnt (
        .clk(clk), .rst(rst), .clr(clr_stats), .inc(w_inc_over),
        .inc_amount(1'b1), .count(oversize_cnt)
    );

    eth_sat_counter #(.WIDTH(CNT_WIDTH + 8), .INC_WIDTH(16)) u_byte_cnt (
        .clk(clk), .rst(rst), .clr(clr_stats), .inc(w_inc_good),
        .inc_amount(w_frame_len), .count(byte_cnt)
    );

endmodule
